// File: rtl/sha1_pkg.sv
// Shared SHA-1 message schedule constants, types and helpers.
// Holds the fixed word/block/round sizes, the IDLE/RUN state encoding
// and the rotate-left-by-one used by the W expansion.
package sha1_pkg;

  localparam int unsigned SHA1_WORD_W    = 32;
  localparam int unsigned SHA1_ROUNDS    = 80;
  localparam int unsigned SHA1_BLOCK_W   = 512;
  localparam int unsigned SHA1_BUF_DEPTH = SHA1_BLOCK_W / SHA1_WORD_W;
  localparam int unsigned SHA1_ROUND_W   = 7;

  localparam logic [SHA1_ROUND_W-1:0] SHA1_LAST_ROUND = SHA1_ROUND_W'(SHA1_ROUNDS - 1);

  typedef logic [SHA1_WORD_W-1:0] sha1_word_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } sha1_state_e;

  // Circular left rotate by one bit position.
  function automatic sha1_word_t rotl1(input sha1_word_t x);
    return {x[SHA1_WORD_W-2:0], x[SHA1_WORD_W-1]};
  endfunction

endpackage

// File: rtl/sha1_message_schedule_if.sv
// Block-in / word-out handshake bundle for the SHA-1 message schedule.
//   blk_valid/blk_ready/blk : 512-bit padded block offered by the producer
//   w_valid/w_ready/w       : schedule word stream to the compression rounds
//   round, w_last           : round index aligned with w, last-word marker
// slave  = schedule block side, master = producer/consumer side.
interface sha1_message_schedule_if;
  import sha1_pkg::*;

  logic                    blk_valid;
  logic                    blk_ready;
  logic [SHA1_BLOCK_W-1:0] blk;
  logic                    w_valid;
  logic                    w_ready;
  sha1_word_t              w;
  logic [SHA1_ROUND_W-1:0] round;
  logic                    w_last;

  modport slave (
    input  blk_valid, blk, w_ready,
    output blk_ready, w_valid, w, round, w_last
  );

  modport master (
    output blk_valid, blk, w_ready,
    input  blk_ready, w_valid, w, round, w_last
  );

endinterface

// File: rtl/sha1_w_next.sv
// SHA-1 schedule expansion: next word from a 16-deep sliding window.
//   w0, w2, w8, w13 : window entries holding W[t], W[t+2], W[t+8], W[t+13]
//   w_next          : W[t+16] = rotl1(W[t+13] ^ W[t+8] ^ W[t+2] ^ W[t])
module sha1_w_next
  import sha1_pkg::*;
(
  input  sha1_word_t w0,
  input  sha1_word_t w2,
  input  sha1_word_t w8,
  input  sha1_word_t w13,
  output sha1_word_t w_next
);

  assign w_next = rotl1(w13 ^ w8 ^ w2 ^ w0);

endmodule

// File: rtl/sha1_message_schedule.sv
// SHA-1 message schedule generator.
// Accepts one 512-bit padded block in IDLE, then streams W[0..79] with a
// valid/ready handshake, one word per accepted beat.
//   clk  : single rising-edge clock
//   rst  : synchronous active-high reset
//   bus  : sha1_message_schedule_if.slave (block in, schedule words out)
// The 16-word window always holds W[t..t+15]; on each handshake it shifts
// down one entry and the freshly expanded word enters at the top.
module sha1_message_schedule
  import sha1_pkg::*;
(
  input logic                     clk,
  input logic                     rst,
  sha1_message_schedule_if.slave  bus
);

  sha1_state_e             state;
  sha1_word_t              word_buf [SHA1_BUF_DEPTH];
  logic [SHA1_ROUND_W-1:0] round_q;
  sha1_word_t              w_next;
  logic                    last_beat;

  assign last_beat = (round_q == SHA1_LAST_ROUND);

  // Expansion of W[t+16] from the current window.
  sha1_w_next u_w_next (
    .w0     (word_buf[0]),
    .w2     (word_buf[2]),
    .w8     (word_buf[8]),
    .w13    (word_buf[13]),
    .w_next (w_next)
  );

  // State, round counter and word window.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      round_q <= '0;
      for (int unsigned i = 0; i < SHA1_BUF_DEPTH; i++) begin
        word_buf[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (bus.blk_valid) begin
            // Word 0 sits in the most significant 32 bits of the block.
            for (int unsigned i = 0; i < SHA1_BUF_DEPTH; i++) begin
              word_buf[i] <= bus.blk[(SHA1_BUF_DEPTH-1-i)*SHA1_WORD_W +: SHA1_WORD_W];
            end
            round_q <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (bus.w_ready) begin
            if (last_beat) begin
              // Window contents are dead after W[79]; leave them as-is.
              round_q <= '0;
              state   <= IDLE;
            end else begin
              for (int unsigned i = 0; i < SHA1_BUF_DEPTH-1; i++) begin
                word_buf[i] <= word_buf[i+1];
              end
              word_buf[SHA1_BUF_DEPTH-1] <= w_next;
              round_q <= round_q + SHA1_ROUND_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // All outputs decode directly from flops; no input-to-output paths.
  assign bus.blk_ready = (state == IDLE);
  assign bus.w_valid   = (state == RUN);
  assign bus.w         = word_buf[0];
  assign bus.round     = round_q;
  assign bus.w_last    = (state == RUN) && last_beat;

endmodule

// File: tb/tb_sha1_message_schedule.sv
// Directed bench for sha1_message_schedule: reference W expansion model,
// table of hand-computed words, stall/reset/back-to-back sequences.
module tb_sha1_message_schedule;
  import sha1_pkg::*;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  sha1_message_schedule_if bus();

  sha1_message_schedule dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;
  int beats_total = 0;

  logic [31:0]  model_w [80];
  logic [31:0]  cap     [80];
  logic [511:0] abc_blk;
  logic [511:0] ones_blk;
  logic [511:0] c_blk;

  typedef struct {
    int          blk_id;   // 0 = "abc" block, 1 = all-ones block
    int          t;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Straight array form of the FIPS 180-4 recurrence.
  task automatic compute_model(input logic [511:0] b);
    logic [31:0] m;
    for (int t = 0; t < 16; t++) model_w[t] = b[(15-t)*32 +: 32];
    for (int t = 16; t < 80; t++) begin
      m = model_w[t-3] ^ model_w[t-8] ^ model_w[t-14] ^ model_w[t-16];
      model_w[t] = {m[30:0], m[31]};
    end
  endtask

  // Offer a block in IDLE; one posedge later it must be accepted.
  task automatic accept_block(input logic [511:0] b, input bit keep_valid);
    check("blk_ready_idle", 64'(bus.blk_ready), 64'(1));
    bus.blk       = b;
    bus.blk_valid = 1'b1;
    @(negedge clk);
    bus.blk_valid = keep_valid;
  endtask

  // Consume n beats against model_w, optionally with random stalls.
  task automatic run_beats(input int n, input bit stall);
    int          idx  = 0;
    int          cyc  = 0;
    bit          hold = 1'b0;
    bit          rdy;
    logic [31:0] pw = '0;
    logic [6:0]  pr = '0;
    while (idx < n && cyc < 1000) begin
      check("w_valid", 64'(bus.w_valid), 64'(1));
      check("blk_ready_run", 64'(bus.blk_ready), 64'(0));
      if (hold) begin
        check($sformatf("w_hold_t%0d", idx), 64'(bus.w), 64'(pw));
        check("round_hold", 64'(bus.round), 64'(pr));
      end
      check("round", 64'(bus.round), 64'(idx));
      check($sformatf("w_last_t%0d", idx), 64'(bus.w_last), 64'(idx == 79));
      check($sformatf("w_t%0d", idx), 64'(bus.w), 64'(model_w[idx]));
      cap[idx] = bus.w;
      rdy = stall ? ($urandom_range(0, 1) == 1) : 1'b1;
      bus.w_ready = rdy;
      pw   = bus.w;
      pr   = bus.round;
      hold = !rdy;
      if (rdy) begin
        idx++;
        beats_total++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.w_ready = 1'b0;
    if (idx < n) check("beat_timeout", 64'(idx), 64'(n));
    if (n == 80) begin
      check("w_valid_after_last", 64'(bus.w_valid), 64'(0));
      check("blk_ready_after_last", 64'(bus.blk_ready), 64'(1));
      check("w_last_after_last", 64'(bus.w_last), 64'(0));
    end
  endtask

  task automatic check_table(input int id);
    foreach (vecs[k]) begin
      if (vecs[k].blk_id == id)
        check($sformatf("vec%0d_W%0d", id, vecs[k].t), 64'(cap[vecs[k].t]), 64'(vecs[k].exp));
    end
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_blk_ready"}, 64'(bus.blk_ready), 64'(1));
    check({tag, "_w_valid"},   64'(bus.w_valid),   64'(0));
    check({tag, "_round"},     64'(bus.round),     64'(0));
    check({tag, "_w"},         64'(bus.w),         64'(0));
    check({tag, "_w_last"},    64'(bus.w_last),    64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;

    abc_blk  = {32'h61626380, 448'h0, 32'h00000018};
    ones_blk = '1;
    for (int i = 0; i < 16; i++) c_blk[(15-i)*32 +: 32] = 32'h01234567 ^ (32'(i) * 32'h11111111);

    vecs.push_back('{0, 0,  32'h61626380});
    vecs.push_back('{0, 1,  32'h00000000});
    vecs.push_back('{0, 14, 32'h00000000});
    vecs.push_back('{0, 15, 32'h00000018});
    vecs.push_back('{0, 16, 32'hC2C4C700});
    vecs.push_back('{0, 17, 32'h00000000});
    vecs.push_back('{0, 18, 32'h00000030});
    vecs.push_back('{1, 0,  32'hFFFFFFFF});
    vecs.push_back('{1, 15, 32'hFFFFFFFF});
    vecs.push_back('{1, 16, 32'h00000000});

    // Reset with a block offered: must not be accepted while rst is high.
    rst           = 1'b1;
    bus.blk       = abc_blk;
    bus.blk_valid = 1'b1;
    bus.w_ready   = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_reset_state("reset");

    // Release reset with blk_valid still high: first free cycle accepts.
    compute_model(abc_blk);
    rst = 1'b0;
    @(negedge clk);
    bus.blk_valid = 1'b0;
    run_beats(80, 1'b0);
    check_table(0);

    // Same block with random backpressure.
    accept_block(abc_blk, 1'b0);
    run_beats(80, 1'b1);
    check_table(0);

    // Reset mid-RUN at round 37, then restart on a fresh block.
    accept_block(abc_blk, 1'b0);
    run_beats(37, 1'b1);
    check("round_before_rst", 64'(bus.round), 64'(37));
    rst = 1'b1;
    @(negedge clk);
    check_reset_state("mid_rst");
    rst = 1'b0;
    compute_model(ones_blk);
    accept_block(ones_blk, 1'b0);
    run_beats(80, 1'b0);
    check_table(1);

    // blk_valid held through RUN with other data; back-to-back blocks.
    base = beats_total;
    compute_model(abc_blk);
    accept_block(abc_blk, 1'b1);
    bus.blk = c_blk;
    run_beats(80, 1'b0);
    compute_model(c_blk);
    @(negedge clk);
    bus.blk_valid = 1'b0;
    run_beats(80, 1'b1);
    check("b2b_beats", 64'(beats_total - base), 64'(160));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
